// File: rtl/nat_tuple_traffic_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nat_tuple_traffic_gen                                                    |
// | AXI-Stream 5-tuple frame generator and return-path checker for NAT soak. |
// | Optional: GEN_RANDOM_STALL_EN adds inter-frame gaps and RX backpressure. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nat_tuple_traffic_gen #(
  parameter int          DATA_WIDTH  = 64,
  parameter int          FRAME_BYTES = 64,
  parameter logic [31:0] NUM_TUPLES  = 32'd1024,
  parameter int          EXP_DEPTH   = 16,
  parameter logic [31:0] REPEAT_MASK = 32'd1,
  parameter logic [7:0]  PROTO       = 8'h06,
  parameter logic [31:0] SEED        = 32'h1ACE_B00C
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             pass_cnt,
  output logic [31:0]             err_cnt,
  output logic [31:0]             first_err_idx,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BEATS = FRAME_BYTES / BYTES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int AW    = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(EXP_DEPTH);
  localparam logic [31:0]   POLY      = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_SEND, S_DRAIN} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Tuple packing: {src_ip, dst_ip, src_port, dst_port}, each field LSB first on the wire.
  function automatic logic [7:0] frame_byte(input int k, input logic [95:0] t);
    logic [7:0] b;
    b = 8'h00;
    if (k == 0)                   b = 8'h01;
    else if (k == 12)             b = 8'h08;
    else if (k == 13)             b = 8'h06;
    else if (k == 23)             b = PROTO;
    else if (k >= 26 && k <= 29)  b = 8'(t >> (64 + 8 * (k - 26)));
    else if (k >= 30 && k <= 33)  b = 8'(t >> (32 + 8 * (k - 30)));
    else if (k >= 34 && k <= 35)  b = 8'(t >> (16 + 8 * (k - 34)));
    else if (k >= 36 && k <= 37)  b = 8'(t >> (8 * (k - 36)));
    return b;
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      gen_cnt_q, gen_cnt_d;
  logic [95:0]     draw_q, draw_d;
  logic [95:0]     tuple_q, tuple_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [31:0]     tx_idx_q, tx_idx_d;
  logic [31:0]     rx_idx_q, rx_idx_d;
  logic [31:0]     pass_q, pass_d;
  logic [31:0]     err_q, err_d;
  logic [31:0]     first_err_q, first_err_d;
  logic            done_q, done_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     rx_beat_q, rx_beat_d;
  logic [119:0]    cap_q, cap_d;
  logic [95:0]     fifo_mem [EXP_DEPTH];

  logic            w_push, w_pop, w_tx_hs, w_rx_hs, w_match;
  logic [31:0]     w_lfsr_next;
  logic [119:0]    w_cap_next, w_exp_vec;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic            unused_tkeep;

  assign unused_tkeep  = ^s_axis_tkeep;
  assign w_lfsr_next   = lfsr_step(lfsr_q);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign pass_cnt      = pass_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_err_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tlast  = (state_q == S_SEND) && (beat_q == LAST_BEAT);
  assign m_axis_tdata  = (state_q == S_SEND) ? w_beat_data : '0;
  assign w_tx_hs       = m_axis_tvalid && m_axis_tready;
  assign w_rx_hs       = s_axis_tvalid && s_axis_tready;

`ifdef GEN_RANDOM_STALL_EN
  logic        gap_q, gap_d;
  logic [15:0] rx_lfsr_q, rx_lfsr_d;
  logic        w_gen_hold;
  assign w_gen_hold    = gap_q;
  assign s_axis_tready = busy && !rx_lfsr_q[0];

  always_comb begin
    gap_d     = gap_q;
    rx_lfsr_d = rx_lfsr_q;
    if (busy) rx_lfsr_d = {1'b0, rx_lfsr_q[15:1]} ^ (rx_lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (state_q == S_GEN) gap_d = 1'b0;
    if (state_q == S_SEND && w_tx_hs && beat_q == LAST_BEAT) gap_d = lfsr_q[5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= 1'b0;
      rx_lfsr_q <= 16'hACE1;
    end else begin
      gap_q     <= gap_d;
      rx_lfsr_q <= rx_lfsr_d;
    end
  end
`else
  logic w_gen_hold;
  assign w_gen_hold    = 1'b0;
  assign s_axis_tready = busy;
`endif

  always_comb begin
    w_beat_data = '0;
    for (int j = 0; j < BYTES; j++)
      w_beat_data[8*j +: 8] = frame_byte(int'(beat_q) * BYTES + j, tuple_q);
  end

  // Captured window covers bytes 23..37; 24 and 25 are never written and stay 0.
  always_comb begin
    w_cap_next = cap_q;
    w_exp_vec  = '0;
    for (int p = 0; p < 15; p++) begin
      w_exp_vec[8*p +: 8] = frame_byte(23 + p, fifo_mem[rd_ptr_q]);
      if (p != 1 && p != 2 && rx_beat_q == 16'((23 + p) / BYTES))
        w_cap_next[8*p +: 8] = s_axis_tdata[8*((23 + p) % BYTES) +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    gen_cnt_d   = gen_cnt_q;
    draw_d      = draw_q;
    tuple_d     = tuple_q;
    lfsr_d      = lfsr_q;
    beat_d      = beat_q;
    tx_idx_d    = tx_idx_q;
    rx_idx_d    = rx_idx_q;
    pass_d      = pass_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    done_d      = done_q;
    rx_beat_d   = rx_beat_q;
    cap_d       = cap_q;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_match     = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_GEN;
        gen_cnt_d   = 2'd0;
        tx_idx_d    = 32'd0;
        rx_idx_d    = 32'd0;
        pass_d      = 32'd0;
        err_d       = 32'd0;
        first_err_d = 32'hFFFF_FFFF;
        done_d      = 1'b0;
      end
      S_GEN: if (!w_gen_hold) begin
        lfsr_d    = w_lfsr_next;
        gen_cnt_d = gen_cnt_q + 2'd1;
        case (gen_cnt_q)
          2'd0:    draw_d[95:64] = w_lfsr_next;
          2'd1:    draw_d[63:32] = w_lfsr_next;
          2'd2:    draw_d[31:0]  = w_lfsr_next;
          default: begin
            tuple_d = (tx_idx_q != 32'd0 && (w_lfsr_next & REPEAT_MASK) != 32'd0) ? tuple_q : draw_q;
            state_d = S_WAIT;
          end
        endcase
      end
      S_WAIT: if (count_q != DEPTH) begin
        w_push  = 1'b1;
        beat_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: if (w_tx_hs) begin
        if (beat_q == LAST_BEAT) begin
          beat_d    = '0;
          gen_cnt_d = 2'd0;
          tx_idx_d  = tx_idx_q + 32'd1;
          state_d   = (tx_idx_q == NUM_TUPLES - 32'd1) ? S_DRAIN : S_GEN;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_DRAIN: if (rx_idx_q == NUM_TUPLES) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_rx_hs) begin
      cap_d     = w_cap_next;
      rx_beat_d = rx_beat_q + 16'd1;
      if (s_axis_tlast) begin
        cap_d     = '0;
        rx_beat_d = 16'd0;
        rx_idx_d  = sat_inc(rx_idx_q);
        if (count_q != '0) begin
          w_pop   = 1'b1;
          w_match = (w_cap_next == w_exp_vec);
        end
        if (w_match) begin
          pass_d = sat_inc(pass_q);
        end else begin
          err_d = sat_inc(err_q);
          if (first_err_q == 32'hFFFF_FFFF) first_err_d = rx_idx_q;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_pop)      count_d = count_q + (AW + 1)'(1);
    else if (!w_push && w_pop) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) fifo_mem[wr_ptr_q] <= tuple_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gen_cnt_q   <= 2'd0;
      draw_q      <= '0;
      tuple_q     <= '0;
      lfsr_q      <= SEED;
      beat_q      <= '0;
      tx_idx_q    <= 32'd0;
      rx_idx_q    <= 32'd0;
      pass_q      <= 32'd0;
      err_q       <= 32'd0;
      first_err_q <= 32'hFFFF_FFFF;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_beat_q   <= 16'd0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      gen_cnt_q   <= gen_cnt_d;
      draw_q      <= draw_d;
      tuple_q     <= tuple_d;
      lfsr_q      <= lfsr_d;
      beat_q      <= beat_d;
      tx_idx_q    <= tx_idx_d;
      rx_idx_q    <= rx_idx_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_beat_q   <= rx_beat_d;
      cap_q       <= cap_d;
    end
  end
endmodule
`default_nettype wire
